// File: rtl/sat_alu_arbiter_pkg.sv
// Shared width, guard-band limits and op encodings for the
// saturating add/sub arbiter slice.
package sat_alu_arbiter_pkg;

  localparam int DATA_W = 25;

  localparam logic [DATA_W-1:0] SAT_MAX =
    {2'b00, {(DATA_W-2){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN =
    {2'b11, {(DATA_W-2){1'b0}}};

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/sat_addsub.sv
// Combinational signed add/sub of two N-bit operands, clamped to
// the guard-band range [SAT_MIN, SAT_MAX].
module sat_addsub
  import sat_alu_arbiter_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y,
  output logic         sat
);

  localparam logic signed [N:0] HI = {3'b000, {(N-2){1'b1}}};
  localparam logic signed [N:0] LO = {3'b111, {(N-2){1'b0}}};

  logic signed [N:0] ea;
  logic signed [N:0] eb;
  logic signed [N:0] sum;

  // One extra bit keeps a - (-2^(N-1)) exact.
  always_comb begin
    ea  = {a[N-1], a};
    eb  = {b[N-1], b};
    sum = (op == OP_SUB) ? (ea - eb) : (ea + eb);
    y   = sum[N-1:0];
    sat = 1'b0;
    if (sum > HI) begin
      y   = HI[N-1:0];
      sat = 1'b1;
    end else if (sum < LO) begin
      y   = LO[N-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/sat_alu_arbiter.sv
// Round-robin arbiter sharing one saturating add/sub unit among
// NREQ requesters, two-stage pipeline plus saturation counter.
module sat_alu_arbiter
  import sat_alu_arbiter_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_op,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [N-1:0]      rsp_data,
  output logic              rsp_sat,
  output logic [CNT_W-1:0]  sat_count,
  input  logic              sat_clr,
  output logic              busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [PW-1:0]    ptr_q, ptr_d, win;
  logic             gnt;
  logic             s1_vld_q, s1_vld_d;
  logic             s1_op_q, s1_op_d;
  logic [N-1:0]     s1_a_q, s1_a_d;
  logic [N-1:0]     s1_b_q, s1_b_d;
  logic [PW-1:0]    s1_idx_q, s1_idx_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [N-1:0]     rsp_data_q, rsp_data_d;
  logic             rsp_sat_q, rsp_sat_d;
  logic [CNT_W-1:0] sat_count_q, sat_count_d;
  logic [N-1:0]     alu_y;
  logic             alu_sat;

  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin : arb
    int j;
    j         = 0;
    gnt       = 1'b0;
    win       = ptr_q;
    req_ready = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (req_valid[j]) begin
        gnt = 1'b1;
        win = PW'(j);
      end
    end
    if (gnt) req_ready[win] = 1'b1;
  end

  always_comb begin
    ptr_d    = ptr_q;
    s1_vld_d = gnt;
    s1_op_d  = s1_op_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_idx_d = s1_idx_q;
    if (gnt) begin
      ptr_d    = (win == LAST) ? '0 : win + PW'(1);
      s1_op_d  = req_op[win];
      s1_a_d   = req_a[int'(win)*N +: N];
      s1_b_d   = req_b[int'(win)*N +: N];
      s1_idx_d = win;
    end
  end

  sat_addsub #(.N(N)) u_alu (
    .op  (s1_op_q),
    .a   (s1_a_q),
    .b   (s1_b_q),
    .y   (alu_y),
    .sat (alu_sat)
  );

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    rsp_sat_d   = rsp_sat_q;
    if (s1_vld_q) begin
      rsp_valid_d[s1_idx_q] = 1'b1;
      rsp_data_d            = alu_y;
      rsp_sat_d             = alu_sat;
    end
  end

  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clr) begin
      sat_count_d = '0;
    end else if ((|rsp_valid_q) && rsp_sat_q && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_op_q     <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_idx_q    <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_vld_q    <= s1_vld_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_idx_q    <= s1_idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_sat_q   <= rsp_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_sat   = rsp_sat_q;
  assign sat_count = sat_count_q;
  assign busy      = s1_vld_q | (|rsp_valid_q);

endmodule

// File: tb/tb_sat_alu_arbiter.sv
// Randomized bench for sat_alu_arbiter against an integer-arithmetic
// model, plus directed literal checks of the key scenarios.
module tb_sat_alu_arbiter;
  import sat_alu_arbiter_pkg::*;

  localparam int N    = DATA_W;
  localparam int NREQ = 4;
  localparam int CW   = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [N-1:0]      rsp_data;
  logic              rsp_sat;
  logic [CW-1:0]     sat_count;
  logic              sat_clr;
  logic              busy;

  sat_alu_arbiter #(.N(N), .NREQ(NREQ), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_sat   (rsp_sat),
    .sat_count (sat_count),
    .sat_clr   (sat_clr),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // ---- reference model ----
  localparam longint HI = (longint'(1) <<< (N - 2)) - 1;
  localparam longint LO = -(longint'(1) <<< (N - 2));

  function automatic longint sx(input logic [N-1:0] v);
    return v[N-1] ? longint'(v) - (longint'(1) <<< N) : longint'(v);
  endfunction

  task automatic ref_op(input logic op, input logic [N-1:0] a,
                        input logic [N-1:0] b,
                        output logic [N-1:0] y, output logic s);
    longint r;
    r = op ? sx(a) - sx(b) : sx(a) + sx(b);
    s = 1'b0;
    if (r > HI) begin r = HI; s = 1'b1; end
    else if (r < LO) begin r = LO; s = 1'b1; end
    y = r[N-1:0];
  endtask

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++)
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Two-slot delay line: [0] accepted last edge, [1] now responding.
  bit          armed = 0;
  int          m_ptr;
  bit          d_v[2];
  int          d_i[2];
  logic [N-1:0] d_y[2];
  logic        d_s[2];
  logic [N-1:0] m_data;
  logic        m_sat;
  int          m_cnt;
  int          cw;
  logic [N-1:0] cy;
  logic        cs;

  always @(negedge clk) begin
    cw = pick(req_valid, m_ptr);
    if (armed) begin
      chk("req_ready", req_ready, (cw >= 0) ? (1 << cw) : 0);
      chk("rsp_valid", rsp_valid, d_v[1] ? (1 << d_i[1]) : 0);
      chk("rsp_data", rsp_data, m_data);
      if (d_v[1]) chk("rsp_sat", rsp_sat, m_sat);
      chk("sat_count", sat_count, m_cnt);
      chk("busy", busy, d_v[0] | d_v[1]);
    end
    if (reset) begin
      armed  = 1;
      m_ptr  = 0;
      d_v    = '{0, 0};
      m_data = '0;
      m_sat  = 1'b0;
      m_cnt  = 0;
    end else if (armed) begin
      if (sat_clr) m_cnt = 0;
      else if (d_v[1] && m_sat && m_cnt < (1 << CW) - 1) m_cnt++;
      if (d_v[0]) begin
        m_data = d_y[0];
        m_sat  = d_s[0];
      end
      d_v[1] = d_v[0];
      d_i[1] = d_i[0];
      d_y[1] = d_y[0];
      d_s[1] = d_s[0];
      d_v[0] = (cw >= 0);
      if (cw >= 0) begin
        ref_op(req_op[cw], req_a[cw*N +: N], req_b[cw*N +: N], cy, cs);
        d_i[0] = cw;
        d_y[0] = cy;
        d_s[0] = cs;
        m_ptr  = (cw + 1) % NREQ;
      end
    end
  end

  // ---- stimulus ----
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic op,
                         input logic [N-1:0] a, input logic [N-1:0] b);
    req_valid[i]     = 1'b1;
    req_op[i]        = op;
    req_a[i*N +: N]  = a;
    req_b[i*N +: N]  = b;
  endtask

  task automatic single(input string nm, input int i, input logic op,
                        input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] ey, input logic es);
    set_req(i, op, a, b);
    #1 chk({nm, " ready"}, req_ready, 1 << i);
    tick;
    req_valid = '0;
    tick;
    #1;
    chk({nm, " valid"}, rsp_valid, 1 << i);
    chk({nm, " data"}, rsp_data, ey);
    chk({nm, " sat"}, rsp_sat, es);
  endtask

  function automatic logic [N-1:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return SAT_MAX;
      1: return SAT_MIN;
      2: return {1'b1, {(N-1){1'b0}}};
      3: return N'($urandom_range(0, 7));
      4: return N'(-int'($urandom_range(1, 8)));
      5: return {1'b0, {(N-1){1'b1}}};
      default: return N'($urandom);
    endcase
  endfunction

  logic [NREQ-1:0] g;
  int              tally[NREQ];

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    sat_clr   = 1'b0;
    repeat (2) tick;
    reset = 1'b0;
    tick;
    chk("reset sat_count", sat_count, 0);
    chk("reset busy", busy, 0);

    single("add100_23", 0, OP_ADD, 25'd100, 25'd23, 25'd123, 1'b0);
    sat_clr = 1'b1;
    tick;
    sat_clr = 1'b0;
    single("max_plus1", 1, OP_ADD, SAT_MAX, 25'd1, SAT_MAX, 1'b1);
    single("min_minus1", 2, OP_SUB, SAT_MIN, 25'd1, SAT_MIN, 1'b1);
    single("exact_max", 3, OP_ADD, SAT_MAX - 25'd5, 25'd5, SAT_MAX,
           1'b0);
    chk("sat_count two", sat_count, 2);
    single("exact_min", 0, OP_SUB, SAT_MIN + 25'd7, 25'd7, SAT_MIN,
           1'b0);
    single("sub_minb", 1, OP_SUB, 25'd0, 25'h1000000, SAT_MAX, 1'b1);

    // Round robin with all requesters permanently valid.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      set_req(i, i[0], N'(i * 10), N'(i));
      tally[i] = 0;
    end
    for (int k = 0; k < 12; k++) begin
      #1 chk("rr grant", req_ready, 1 << (k % NREQ));
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) tally[i]++;
      tick;
    end
    for (int i = 0; i < NREQ; i++) chk("rr share", tally[i], 3);
    req_valid = '0;
    repeat (3) tick;

    // Counter saturates at all ones, then clear beats an increment.
    sat_clr = 1'b1;
    tick;
    sat_clr = 1'b0;
    set_req(0, OP_ADD, SAT_MAX, SAT_MAX);
    repeat (70) tick;
    chk("cnt stuck", sat_count, (1 << CW) - 1);
    sat_clr = 1'b1;
    tick;
    sat_clr = 1'b0;
    chk("cnt clr wins", sat_count, 0);
    req_valid = '0;
    repeat (3) tick;

    // Reset one cycle after an accept.
    set_req(1, OP_ADD, 25'd5, 25'd6);
    tick;
    req_valid = '0;
    reset     = 1'b1;
    tick;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst no rsp", rsp_valid, 0);
      chk("rst busy", busy, 0);
      tick;
    end
    req_valid = '1;
    #1 chk("rst ptr0", req_ready, 1);
    tick;
    req_valid = '0;
    repeat (3) tick;

    // Random traffic obeying the hold-until-ready rule.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      g = req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || g[i]) begin
          req_valid[i]    = ($urandom_range(0, 99) < 60);
          req_op[i]       = 1'($urandom_range(0, 1));
          req_a[i*N +: N] = rnd_val();
          req_b[i*N +: N] = rnd_val();
        end
      end
      sat_clr = ($urandom_range(0, 49) == 0);
      reset   = ($urandom_range(0, 199) == 0);
    end
    req_valid = '0;
    reset     = 1'b0;
    sat_clr   = 1'b0;
    repeat (4) tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
